// File: rtl/senone_sender.sv
// senone_sender: streams n_senones signed 16-bit words from SRAM to the
// UART transmit slot, one value per transfer, in ascending address order.
module senone_sender #(
    parameter int unsigned n_senones = 1000,
    parameter logic [20:0] base_addr = 21'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_send,
    output logic               send_done,
    output logic               new_vector_incoming,
    input  logic               uart_ready,
    output logic               start_tx,
    output logic signed [15:0] tx_value,
    output logic [20:0]        data_addr,
    output logic               read_data,
    input  logic               sram_idle,
    input  logic               sram_ready,
    input  logic signed [15:0] data_in
);
    localparam int IW = (n_senones > 1) ? $clog2(n_senones) : 1;
    localparam logic [IW-1:0] LAST = IW'(n_senones - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        WAIT_UART,
        WAIT_ACCEPT,
        NEXT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_idx;
    logic               r_nvi;
    logic signed [15:0] r_tx;
    logic               w_last;
    logic               w_accept;
    logic [20:0]        w_off;

    assign w_last   = (r_idx == LAST);
    assign w_accept = (r_state == IDLE) && start_send;
    assign w_off    = 21'(r_idx) << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (start_send)  w_next = REQ;
            REQ:         if (sram_idle)   w_next = WAIT_DATA;
            WAIT_DATA:   if (sram_ready)  w_next = WAIT_UART;
            WAIT_UART:   if (uart_ready)  w_next = WAIT_ACCEPT;
            WAIT_ACCEPT: if (!uart_ready) w_next = NEXT;
            NEXT:        w_next = w_last ? IDLE : REQ;
            default:     w_next = IDLE;
        endcase
    end

    // Handshake strobes are decoded from state so an abort by reset
    // silences them immediately.
    always_comb begin
        read_data = 1'b0;
        start_tx  = 1'b0;
        send_done = 1'b0;
        case (r_state)
            REQ:       read_data = sram_idle;
            WAIT_UART: start_tx  = uart_ready;
            NEXT:      send_done = w_last;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_nvi <= 1'b0;
            r_tx  <= '0;
        end else begin
            r_nvi <= w_accept;
            if (w_accept) begin
                r_idx <= '0;
            end else if (r_state == NEXT && !w_last) begin
                r_idx <= r_idx + IW'(1);
            end
            if (r_state == WAIT_DATA && sram_ready) begin
                r_tx <= data_in;
            end
        end
    end

    assign new_vector_incoming = r_nvi;
    assign tx_value            = r_tx;
    assign data_addr           = base_addr + w_off;

endmodule

// File: tb/tb_senone_sender.sv
// tb_senone_sender: randomized SRAM/UART responders around senone_sender,
// checked against a per-pass model of the expected address/value stream.
`timescale 1ns/1ps
module tb_senone_sender;
    localparam int N = 5;
    localparam logic [20:0] BASE = 21'h0;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_send;
    logic               send_done;
    logic               nvi;
    logic               uart_ready;
    logic               start_tx;
    logic signed [15:0] tx_value;
    logic [20:0]        data_addr;
    logic               read_data;
    logic               sram_idle;
    logic               sram_ready;
    logic signed [15:0] data_in;

    senone_sender #(.n_senones(N), .base_addr(BASE)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_send          (start_send),
        .send_done           (send_done),
        .new_vector_incoming (nvi),
        .uart_ready          (uart_ready),
        .start_tx            (start_tx),
        .tx_value            (tx_value),
        .data_addr           (data_addr),
        .read_data           (read_data),
        .sram_idle           (sram_idle),
        .sram_ready          (sram_ready),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mem [0:1023];
    bit  blk = 1'b0;
    int  lat_extra = 0;

    logic [20:0] rd_q [$];
    logic [15:0] tx_q [$];
    int nvi_cnt = 0;
    int done_cnt = 0;
    int rd_err = 0;
    int addr_err = 0;
    int txv_err = 0;

    // Event monitor: logs strobes and protocol stability at negedge.
    initial begin
        logic        a_lock;
        logic [20:0] a_val;
        logic        prev_rd, prev_rdy, prev_rst;
        logic [15:0] last_tx;
        a_lock = 1'b0; a_val = '0;
        prev_rd = 1'b0; prev_rdy = 1'b0; prev_rst = 1'b1; last_tx = '0;
        forever begin
            @(negedge clk);
            if (read_data) rd_q.push_back(data_addr);
            if (read_data && prev_rd) rd_err++;
            if (start_tx) tx_q.push_back(tx_value);
            if (nvi) nvi_cnt++;
            if (send_done) done_cnt++;
            if (reset) begin
                a_lock = 1'b0;
            end else if (a_lock) begin
                if (data_addr !== a_val) addr_err++;
                if (sram_ready) a_lock = 1'b0;
            end
            if (read_data && !reset) begin
                a_lock = 1'b1;
                a_val  = data_addr;
            end
            if (tx_value !== last_tx && !prev_rdy && !reset && !prev_rst)
                txv_err++;
            last_tx  = tx_value;
            prev_rd  = read_data;
            prev_rdy = sram_ready;
            prev_rst = reset;
        end
    end

    // SRAM controller model: word-wide reads, random busy/latency.
    initial begin
        bit          pend;
        int          lat;
        logic [20:0] a;
        logic        s_rd, s_rst;
        logic [20:0] s_addr;
        pend = 1'b0; lat = 0; a = '0;
        sram_idle = 1'b1; sram_ready = 1'b0; data_in = '0;
        forever begin
            @(negedge clk);
            s_rd = read_data; s_addr = data_addr; s_rst = reset;
            @(posedge clk); #1;
            sram_ready = 1'b0;
            data_in = 16'($urandom);
            if (s_rst) begin
                pend = 1'b0;
                sram_idle = 1'b1;
            end else if (pend) begin
                if (lat == 0) begin
                    sram_ready = 1'b1;
                    data_in = mem[a[10:1]];
                    pend = 1'b0;
                    sram_idle = 1'b1;
                end else begin
                    lat--;
                end
            end else if (s_rd) begin
                pend = 1'b1;
                a = s_addr;
                lat = $urandom_range(0, 3) + lat_extra;
                sram_idle = 1'b0;
            end else begin
                sram_idle = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // UART model: drops ready right after start_tx, busy a few cycles.
    initial begin
        int   busy;
        logic s_tx, s_rst;
        busy = 0;
        uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            s_tx = start_tx; s_rst = reset;
            @(posedge clk); #1;
            if (s_rst) busy = 0;
            else if (s_tx) busy = $urandom_range(1, 4);
            else if (busy > 0) busy--;
            uart_ready = (busy == 0) && !blk && ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [20:0] exp_addr(input int i);
        return BASE + 21'(2 * i);
    endfunction

    function automatic logic [15:0] ref_val(input int i);
        logic [20:0] a;
        a = exp_addr(i);
        return mem[a[10:1]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        tx_q.delete();
        nvi_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_done_in_budget"}, 32'(done_cnt != 0), 1);
    endtask

    task automatic check_pass(input string tag);
        chk({tag, "_nrd"}, rd_q.size(), N);
        chk({tag, "_ntx"}, tx_q.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < rd_q.size())
                chk($sformatf("%s_addr%0d", tag, i), rd_q[i], exp_addr(i));
            if (i < tx_q.size())
                chk($sformatf("%s_val%0d", tag, i), tx_q[i], ref_val(i));
        end
        chk({tag, "_ndone"}, done_cnt, 1);
        chk({tag, "_nnvi"}, nvi_cnt, 1);
    endtask

    task automatic run_pass(input string tag);
        clear_logs();
        start_send = 1'b1;
        @(posedge clk); #2 start_send = 1'b0;
        wait_done(tag, 2000);
        repeat (20) @(posedge clk);
        #2;
        check_pass(tag);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start_send = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < N; i++) mem[i] = 16'h8008 + 16'(i);

        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {send_done, nvi, start_tx, read_data}, 0);
        chk("rst_tx", $unsigned(tx_value), 0);
        chk("rst_addr", data_addr, BASE);

        // Pass 1: start held two cycles yields a single vector.
        repeat (3) @(posedge clk);
        #2 clear_logs();
        start_send = 1'b1;
        @(negedge clk);
        chk("p1_nvi_pre", nvi, 0);
        @(posedge clk); #2;
        @(negedge clk);
        chk("p1_nvi_post", nvi, 1);
        @(posedge clk); #2 start_send = 1'b0;
        wait_done("p1", 2000);
        repeat (20) @(posedge clk);
        #2;
        check_pass("p1");

        // Pass 2: extra start during transfer 2, UART stall on value 3.
        clear_logs();
        start_send = 1'b1;
        @(posedge clk); #2 start_send = 1'b0;
        n = 0;
        while (tx_q.size() < 2 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("p2_reach_tx2", tx_q.size(), 2);
        start_send = 1'b1;
        blk = 1'b1;
        @(posedge clk); #2 start_send = 1'b0;
        repeat (1000) @(posedge clk);
        #2;
        chk("p2_stall_ntx", tx_q.size(), 2);
        chk("p2_stall_nrd", rd_q.size(), 3);
        chk("p2_stall_txv", $unsigned(tx_value), 16'h800A);
        blk = 1'b0;
        wait_done("p2", 2000);
        repeat (20) @(posedge clk);
        #2;
        check_pass("p2");

        // Pass 3: reset while waiting on the second SRAM word.
        lat_extra = 30;
        clear_logs();
        start_send = 1'b1;
        @(posedge clk); #2 start_send = 1'b0;
        n = 0;
        while (rd_q.size() < 2 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("p3_reach_rd2", rd_q.size(), 2);
        reset = 1'b1;
        clear_logs();
        @(negedge clk);
        chk("p3_rst_ctrl", {send_done, nvi, start_tx, read_data}, 0);
        chk("p3_rst_tx", $unsigned(tx_value), 0);
        chk("p3_rst_addr", data_addr, BASE);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        lat_extra = 0;
        repeat (30) @(posedge clk);
        #2;
        chk("p3_abort_nrd", rd_q.size(), 0);
        chk("p3_abort_ntx", tx_q.size(), 0);
        chk("p3_abort_ndone", done_cnt, 0);

        run_pass("p4");

        // 500 us of idle, then the same block again.
        repeat (50000) @(posedge clk);
        #2;
        run_pass("p5");

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        run_pass("p6");

        chk("rd_single_cycle", rd_err, 0);
        chk("addr_stable", addr_err, 0);
        chk("txv_stable", txv_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/senone_sender.md
# senone_sender

Streams a block of `n_senones` signed 16-bit scores from external SRAM out over the serial link, one value per UART transfer. It sits between the SRAM access controller, which performs byte-wide SRAM reads and returns 16-bit words, and the UART transmitter, which has a single 16-bit transmit slot. A `start_send` pulse from the host logic triggers one complete pass over the block. `send_done` pulses when the last value has been handed to the UART.

## Interface
- `n_senones`, default 1000: number of 16-bit values per pass, must be ≥1.
- `base_addr`, default 21'h0: SRAM byte address of value 0.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start_send` in 1: request one pass; sampled only in IDLE.
- `send_done` out 1: one-cycle pulse when the pass completes.
- `new_vector_incoming` out 1: one-cycle pulse to the UART marking the start of a new vector.
- `uart_ready` in 1: high when the UART can accept a value.
- `start_tx` out 1: one-cycle pulse; the UART transmits `tx_value`.
- `tx_value` out 16 (signed): value presented to the UART.
- `data_addr` out 21: SRAM byte address of the requested word.
- `read_data` out 1: one-cycle read request to the SRAM controller.
- `sram_idle` in 1: high when the controller can accept a request.
- `sram_ready` in 1: one-cycle pulse; `data_in` is valid in this cycle.
- `data_in` in 16 (signed): word returned by the controller.

## Operation
- States:
  - IDLE: waits for a pass request.
  - REQ: issues the SRAM read.
  - WAIT_DATA: waits for the word.
  - WAIT_UART: waits for the UART to be free.
  - WAIT_ACCEPT: waits for the UART to take the value.
  - NEXT: advances or finishes.
- Index counter `idx` is a clog2(n_senones)-bit register, range 0..n_senones-1.
- IDLE:
  - `start_send`=1 → `idx`←0, pulse `new_vector_incoming`, go to REQ.
  - `start_send` in any other state is ignored; there is no queuing.
- REQ:
  - `data_addr` = `base_addr` + 2·`idx`, truncated to 21 bits; wrap-around is permitted.
  - When `sram_idle`=1: pulse `read_data` for exactly 1 cycle, then go to WAIT_DATA.
- WAIT_DATA: on `sram_ready`=1, latch `data_in` into `tx_value` and go to WAIT_UART.
- WAIT_UART: when `uart_ready`=1, pulse `start_tx` for 1 cycle and go to WAIT_ACCEPT.
- WAIT_ACCEPT: when `uart_ready`=0, go to NEXT. This guarantees one `start_tx` per value.
- NEXT:
  - `idx`=n_senones-1 → pulse `send_done`, go to IDLE.
  - Otherwise `idx`←`idx`+1, go to REQ.
- Value order is ascending address. `tx_value` is passed unchanged, with no sign or width conversion.

## Timing
- Reset values:
  - State = IDLE, `idx`=0.
  - `send_done`, `new_vector_incoming`, `start_tx`, `read_data` = 0.
  - `tx_value`=0, `data_addr`=`base_addr`.
- Reset asserted mid-pass aborts immediately. No further `read_data` or `start_tx` is issued, and `send_done` is not pulsed.
- `start_send` is accepted in the same edge it is sampled.
  - `new_vector_incoming` is high in the cycle after acceptance.
  - The first `read_data` can occur in that same cycle if `sram_idle`=1.
- `data_addr` is held stable from the `read_data` cycle until `sram_ready`.
- `tx_value` is held stable from latching until the next `sram_ready`. This covers the whole UART transfer.
- The UART must drop `uart_ready` within 1 cycle of `start_tx`. The sender waits indefinitely at every handshake; there are no timeouts.
- Fixed sender overhead is 4 cycles per value, plus SRAM latency and UART transfer time.
- `send_done` is high for one cycle, in the cycle after the last `uart_ready` fall is seen.
- A new `start_send` is accepted from the cycle after `send_done`.

## Test plan
- Reset with `n_senones`=5, `base_addr`=0, and SRAM bytes 0..9 preloaded so that word i = 16'h8008+i → after reset release all outputs are 0.
- Pulse `start_send` for 2 cycles → exactly 1 `new_vector_incoming` pulse.
- Continuing that pass → `read_data` addresses 0,2,4,6,8, and `start_tx` exactly 5 times with `tx_value` 8008,8009,800A,800B,800C.
- Continuing that pass → `send_done` pulses once after the fifth transfer.
- Pulse `start_send` again while transfer 2 is in progress → ignored; exactly 5 values and 1 `send_done` in total.
- Hold `uart_ready`=0 for 1000 cycles during value 3 → the sender stalls with `tx_value`=800A, with no extra `start_tx` or `read_data`.
- Assert `reset` during WAIT_DATA of value 2 → outputs return to 0. Then pulse `start_send` → a full pass restarts from address 0.
- Second `start_send` 500 µs after the first pass → an identical 5-value sequence, with `idx` restarting at 0.
